fetch_decode_stage: RTL and testbench

Instruction fetch and IF/ID stage for the processor pipeline. It sits directly upstream of the control unit.
- Owns the PC and drives the synchronous instruction memory.
- Registers each fetched word and splits it into the tipo/op/Inm fields the control unit consumes, plus register indices and the raw immediate.
- Handles hazard stalls without losing an in-flight word, and handles branch/jump redirects by flushing.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_decode_stage_skid.sv | 51 +++++
 rtl/fetch_decode_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_decode_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, instruction field positions and fetch FSM states for the
// fetch / IF-ID stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int IMM_W   = 19;

  localparam int TIPO_HI = 31;
  localparam int TIPO_LO = 30;
  localparam int OP_HI   = 29;
  localparam int OP_LO   = 28;
  localparam int INM_BIT = 27;
  localparam int RD_HI   = 26;
  localparam int RD_LO   = 23;
  localparam int RN_HI   = 22;
  localparam int RN_LO   = 19;
  localparam int RM_HI   = 18;
  localparam int RM_LO   = 15;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_decode_stage_skid.sv
// One-entry {pc, instr} holding register that parks a response arriving
// while the IF/ID register is stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Clear wins: a flush or a drain must never be overridden by a capture.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch + IF/ID register: owns the PC, drives the synchronous
// instruction memory, absorbs stalls via a skid entry and flushes on redirect.
module fetch_decode_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               id_valid_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [1:0]         tipo_o,
  output logic [1:0]         op_o,
  output logic               inm_o,
  output logic [3:0]         rd_o,
  output logic [3:0]         rn_o,
  output logic [3:0]         rm_o,
  output logic [IMM_W-1:0]   imm_field_o
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               resp_valid_q, resp_valid_d;
  logic [PC_W-1:0]    resp_pc_q, resp_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               req_ok;
  logic               skid_valid, skid_load, skid_clear;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (stall_i && (skid_valid || resp_valid_q)) state_d = HOLD;
      HOLD:    if (!stall_i || redirect_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Requests pause only while stalled with a word already in flight or parked.
  always_comb begin
    req_ok = 1'b0;
    case (state_q)
      BOOT:      req_ok = 1'b1;
      RUN, HOLD: req_ok = redirect_i || !stall_i || (!skid_valid && !resp_valid_q);
      default:   req_ok = 1'b0;
    endcase
    imem_req_o = rst_n && req_ok;
  end

  // The target's own request stays live; only the stale response is dropped.
  always_comb begin
    imem_addr_o  = redirect_i ? redirect_pc_i : pc_q;
    pc_d         = imem_req_o ? imem_addr_o + PC_W'(PC_STEP) : pc_q;
    resp_valid_d = imem_req_o;
    resp_pc_d    = imem_req_o ? imem_addr_o : resp_pc_q;
    skid_load    = !redirect_i && stall_i && resp_valid_q;
    skid_clear   = redirect_i || (!stall_i && skid_valid);
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (redirect_i) begin
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (skid_valid) begin
        id_valid_d = 1'b1;
        id_pc_d    = skid_pc;
        id_instr_d = skid_instr;
      end else if (resp_valid_q) begin
        id_valid_d = 1'b1;
        id_pc_d    = resp_pc_q;
        id_instr_d = imem_rdata_i;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (resp_pc_q),
    .instr_i (imem_rdata_i),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign id_valid_o  = id_valid_q;
  assign id_pc_o     = id_pc_q;
  assign id_instr_o  = id_instr_q;
  assign tipo_o      = id_instr_q[TIPO_HI:TIPO_LO];
  assign op_o        = id_instr_q[OP_HI:OP_LO];
  assign inm_o       = id_instr_q[INM_BIT];
  assign rd_o        = id_instr_q[RD_HI:RD_LO];
  assign rn_o        = id_instr_q[RN_HI:RN_LO];
  assign rm_o        = id_instr_q[RM_HI:RM_LO];
  assign imm_field_o = id_instr_q[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: an in-order program-counter model
// checks every IF/ID cycle, plus literal checks on latency, stall and redirect.
module tb_fetch_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr, rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [1:0]  tipo, op;
  logic        inm;
  logic [3:0]  rd, rn, rm;
  logic [18:0] imm;

  logic        rst2_n;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'h0;
  logic        req2;
  logic [31:0] addr2, rdata2;
  logic        id_valid2;
  logic [31:0] id_pc2, id_instr2;
  logic [1:0]  tipo2, op2;
  logic        inm2;
  logic [3:0]  rd2, rn2, rm2;
  logic [18:0] imm2;

  int compared = 0;
  int mismatched = 0;

  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .id_valid_o(id_valid), .id_pc_o(id_pc),
    .id_instr_o(id_instr), .tipo_o(tipo), .op_o(op), .inm_o(inm),
    .rd_o(rd), .rn_o(rn), .rm_o(rm), .imm_field_o(imm)
  );

  fetch_decode_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall_i(zero_bit), .redirect_i(zero_bit),
    .redirect_pc_i(zero_word), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(rdata2), .id_valid_o(id_valid2), .id_pc_o(id_pc2),
    .id_instr_o(id_instr2), .tipo_o(tipo2), .op_o(op2), .inm_o(inm2),
    .rd_o(rd2), .rn_o(rn2), .rm_o(rm2), .imm_field_o(imm2)
  );

  // Program image: word index + 1 replicated in every nibble, one decode pattern at 0x0C.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h99AA_ABCD;
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  always @(posedge clk) begin
    rdata  <= req  ? memWord(addr)  : 32'hDEAD_BEEF;
    rdata2 <= req2 ? memWord(addr2) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rdr, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    stall = st;
    redirect = rdr;
    redirect_pc = tgt;
    @(negedge clk);
  endtask

  // Program-order model: every live IF/ID word must be the next PC of the
  // current stream, held words must not move, and a redirect must flush.
  logic        lastStall = 1'b0, lastRedirect = 1'b0;
  logic [31:0] lastRedirPc = 32'h0;
  logic [31:0] expPc = 32'h0, modelPc = 32'h0;
  logic        modelValid = 1'b0;

  always @(posedge clk) begin
    lastStall   <= stall;
    lastRedirect <= redirect;
    lastRedirPc <= redirect_pc;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      expPc      <= 32'h0;
      modelValid <= 1'b0;
    end else if (lastRedirect) begin
      checkOutput("sb_flush_valid", 32'(id_valid), 32'h0);
      modelValid <= 1'b0;
      expPc      <= lastRedirPc;
    end else if (lastStall) begin
      checkOutput("sb_hold_valid", 32'(id_valid), 32'(modelValid));
      if (modelValid) begin
        checkOutput("sb_hold_pc", id_pc, modelPc);
        checkOutput("sb_hold_instr", id_instr, memWord(modelPc));
      end
    end else if (id_valid) begin
      checkOutput("sb_pc", id_pc, expPc);
      checkOutput("sb_instr", id_instr, memWord(expPc));
      checkOutput("sb_tipo", 32'(tipo), (memWord(expPc) >> 30) & 32'h3);
      checkOutput("sb_op", 32'(op), (memWord(expPc) >> 28) & 32'h3);
      checkOutput("sb_inm", 32'(inm), (memWord(expPc) >> 27) & 32'h1);
      checkOutput("sb_rd", 32'(rd), (memWord(expPc) >> 23) & 32'hF);
      checkOutput("sb_rn", 32'(rn), (memWord(expPc) >> 19) & 32'hF);
      checkOutput("sb_rm", 32'(rm), (memWord(expPc) >> 15) & 32'hF);
      checkOutput("sb_imm", 32'(imm), memWord(expPc) % 32'h8_0000);
      modelValid <= 1'b1;
      modelPc    <= expPc;
      expPc      <= expPc + 32'd4;
    end else begin
      modelValid <= 1'b0;
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;

    #2;
    checkOutput("rst_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_req", 32'(req), 32'h0);
    checkOutput("rst_pc", id_pc, 32'h0);
    checkOutput("rst_instr", id_instr, 32'h0);
    checkOutput("rst_imm", 32'(imm), 32'h0);

    // Reset release and sequential fetch
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("boot_addr", addr, 32'h0);
    checkOutput("boot_req", 32'(req), 32'h1);
    checkOutput("boot_valid", 32'(id_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c1_addr", addr, 32'h4);
    checkOutput("c1_valid", 32'(id_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c2_addr", addr, 32'h8);
    checkOutput("c2_valid", 32'(id_valid), 32'h1);
    checkOutput("c2_pc", id_pc, 32'h0);
    checkOutput("c2_instr", id_instr, 32'h1111_1111);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c3_pc", id_pc, 32'h4);
    checkOutput("c3_instr", id_instr, 32'h2222_2222);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c4_pc", id_pc, 32'h8);

    // Field split of 10_01_1_0011_0101_...
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("dec_pc", id_pc, 32'hC);
    checkOutput("dec_tipo", 32'(tipo), 32'd2);
    checkOutput("dec_op", 32'(op), 32'd1);
    checkOutput("dec_inm", 32'(inm), 32'd1);
    checkOutput("dec_rd", 32'(rd), 32'd3);
    checkOutput("dec_rn", 32'(rn), 32'd5);
    checkOutput("dec_rm", 32'(rm), 32'd5);
    checkOutput("dec_imm", 32'(imm), 32'h2_ABCD);

    // Three-cycle stall with a word in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall_req", 32'(req), 32'h0);
      checkOutput("stall_pc", id_pc, 32'h10);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("unstall_addr", addr, 32'h18);
    checkOutput("unstall_req", 32'(req), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("skid_pc", id_pc, 32'h14);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("after_skid_pc", id_pc, 32'h18);

    // Redirect to 0x40
    applyStimulus(1'b0, 1'b1, 32'h40);
    checkOutput("redir_addr", addr, 32'h40);
    checkOutput("redir_req", 32'(req), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_bubble", 32'(id_valid), 32'h0);
    checkOutput("redir_next_addr", addr, 32'h44);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_tgt_pc", id_pc, 32'h40);
    checkOutput("redir_tgt_instr", id_instr, 32'h2222_2221);

    // Redirect while stalled with the skid full
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("s5_req0", 32'(req), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("s5_req1", 32'(req), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h80);
    checkOutput("s5_redir_addr", addr, 32'h80);
    checkOutput("s5_redir_req", 32'(req), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("s5_flush", 32'(id_valid), 32'h0);
    checkOutput("s5_hold_req", 32'(req), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("s5_hold_req2", 32'(req), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("s5_release_addr", addr, 32'h84);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("s5_tgt_valid", 32'(id_valid), 32'h1);
    checkOutput("s5_tgt_pc", id_pc, 32'h80);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("model_progress", expPc, 32'h90);

    // Wrapping reset PC and asynchronous mid-stream reset
    @(posedge clk);
    #1 rst2_n = 1'b1;
    @(negedge clk);
    checkOutput("w_boot_addr", addr2, 32'hFFFF_FFF8);
    checkOutput("w_boot_req", 32'(req2), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("w_addr1", addr2, 32'hFFFF_FFFC);
    checkOutput("w_valid1", 32'(id_valid2), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("w_addr2", addr2, 32'h0);
    checkOutput("w_pc2", id_pc2, 32'hFFFF_FFF8);
    checkOutput("w_instr2", id_instr2, 32'h2EEE_EEEF);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("w_pc3", id_pc2, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("w_pc4", id_pc2, 32'h0);
    checkOutput("w_instr4", id_instr2, 32'h1111_1111);
    #2 rst2_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(id_valid2), 32'h0);
    checkOutput("arst_req", 32'(req2), 32'h0);
    checkOutput("arst_pc", id_pc2, 32'h0);
    checkOutput("arst_addr", addr2, 32'hFFFF_FFF8);
    @(posedge clk);
    #1 rst2_n = 1'b1;
    @(negedge clk);
    checkOutput("rb_addr", addr2, 32'hFFFF_FFF8);
    checkOutput("rb_valid", 32'(id_valid2), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rb_addr1", addr2, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rb_valid2", 32'(id_valid2), 32'h1);
    checkOutput("rb_pc2", id_pc2, 32'hFFFF_FFF8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
